logic_unit_pipe: RTL and testbench



---
 rtl/logic_pkg.sv | 52 +++++
 rtl/logic_unit_pipe_if.sv | 30 +++
 rtl/logic_pipe_stage.sv | 41 ++++
 rtl/logic_unit_pipe.sv | 66 ++++++
 tb/tb_logic_unit_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_pkg : opcodes and per-bit op evaluation for logic_unit_pipe        |
// | Macro LOGIC_EXT_OPS_EN enables NAND/XNOR/ANDN/ORN. Rev 1.0               |
// +--------------------------------------------------------------------------+
package logic_pkg;

    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_ANDN = 4'd10;
    localparam logic [3:0] OP_ORN  = 4'd11;

    // Evaluated per bit so the operand width stays a free parameter of the caller;
    // unsupported opcodes yield 0, which makes the zero flag fall out naturally.
    function automatic logic op_result_bit(input logic a, input logic b, input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
`ifdef LOGIC_EXT_OPS_EN
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            OP_ORN:  r = a | ~b;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR: ok = 1'b1;
`ifdef LOGIC_EXT_OPS_EN
            OP_NAND, OP_XNOR, OP_ANDN, OP_ORN: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pipe_if : operand/result handshake bundle for logic_unit_pipe |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] LogicOut;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, LogicOut, zero, illegal
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, LogicOut, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/logic_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_pipe_stage : one-entry valid/ready register slice                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module logic_pipe_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  in_valid,
    output logic                       in_ready,
    input  wire logic [DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  wire logic                  out_ready,
    output logic [DATA_WIDTH-1:0]      out_data
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // Ready ripples combinationally from downstream so a full slice can refill
    // on the same edge it empties.
    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (in_ready) begin
                r_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_data <= in_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pipe : two-stage AND/OR/XOR/NOR unit with zero/illegal flags  |
// | Macro LOGIC_EXT_OPS_EN adds opcodes 8-11. Rev 1.0                        |
// +--------------------------------------------------------------------------+
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    logic_unit_pipe_if.slave  bus
);
    localparam int S1_W = 2 * WIDTH + 4;
    localparam int S2_W = WIDTH + 2;

    logic             w_s1_valid;
    logic [S1_W-1:0]  w_s1_data;
    logic             w_s2_in_ready;
    logic [S2_W-1:0]  w_s2_data;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_op;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_illegal;

    logic_pipe_stage #(.DATA_WIDTH(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.A, bus.B, bus.ALUop}),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_in_ready),
        .out_data  (w_s1_data)
    );

    assign w_a  = w_s1_data[S1_W-1 -: WIDTH];
    assign w_b  = w_s1_data[WIDTH+3 -: WIDTH];
    assign w_op = w_s1_data[3:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign w_result[i] = op_result_bit(w_a[i], w_b[i], w_op);
    end

    assign w_zero    = ~|w_result;
    assign w_illegal = ~op_is_legal(w_op);

    logic_pipe_stage #(.DATA_WIDTH(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_in_ready),
        .in_data   ({w_illegal, w_zero, w_result}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (w_s2_data)
    );

    assign bus.LogicOut = w_s2_data[WIDTH-1:0];
    assign bus.zero     = w_s2_data[WIDTH];
    assign bus.illegal  = w_s2_data[WIDTH+1];
endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_unit_pipe : randomized bench with in-order reference queue      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_logic_unit_pipe;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();
    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             il;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   accepts     = 0;
    int   pops        = 0;
    exp_t exp_q[$];

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [3:0] op);
        exp_t e;
        e.il = 1'b0;
        case (op)
            4'd4:  e.r = a & b;
            4'd5:  e.r = a | b;
            4'd6:  e.r = a ^ b;
            4'd7:  e.r = ~(a | b);
`ifdef LOGIC_EXT_OPS_EN
            4'd8:  e.r = ~(a & b);
            4'd9:  e.r = ~(a ^ b);
            4'd10: e.r = a & ~b;
            4'd11: e.r = a | ~b;
`endif
            default: begin
                e.r  = '0;
                e.il = 1'b1;
            end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Reference scoreboard: sample halfway through the cycle, before the edge that acts on it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got out_valid=1 LogicOut=%h, required no output", bus.LogicOut);
                end else begin
                    e = exp_q[0];
                    if (bus.LogicOut !== e.r || bus.zero !== e.z || bus.illegal !== e.il) begin
                        miscompares++;
                        $display("FAIL result: got %h z=%b il=%b, required %h z=%b il=%b",
                                 bus.LogicOut, bus.zero, bus.illegal, e.r, e.z, e.il);
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.ALUop));
                accepts++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] op, output exp_t got, output bit ok);
        bus.A = a; bus.B = b; bus.ALUop = op; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        ok  = 1'b0;
        got = '0;
        for (int k = 0; k < 8 && !ok; k++) begin
            step();
            if (bus.out_valid) begin
                ok  = 1'b1;
                got = {bus.LogicOut, bus.zero, bus.illegal};
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no out_valid in 8 cycles, required a result");
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) ok = 1'b1;
            else step();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d results still pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]       ops[4];
        logic [WIDTH-1:0] exp_d[4];
        logic [WIDTH-1:0] held;
        exp_t             got;
        bit               ok;
        int               n0;

        ops   = '{4'd4, 4'd5, 4'd6, 4'd7};
        exp_d = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F};

        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ALUop = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_logicout",  bus.LogicOut, 32'd0);
        check("reset_zero",      {31'd0, bus.zero}, 32'd0);
        check("reset_illegal",   {31'd0, bus.illegal}, 32'd0);
        check("reset_in_ready",  {31'd0, bus.in_ready}, 32'd1);

        // Back-to-back ops: first result two edges after it is presented.
        bus.A = 32'hF0F0_F0F0; bus.B = 32'hFF00_FF00;
        bus.ALUop = ops[0]; bus.in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) check("latency_not_early", {31'd0, bus.out_valid}, 32'd0);
            if (i >= 2) begin
                check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
                check("b2b_result", bus.LogicOut, exp_d[i-2]);
            end
            if (i < 4) bus.ALUop = ops[i];
            else       bus.in_valid = 1'b0;
        end
        drain("drain_b2b");

        send_one(32'h1234_5678, 32'h1234_5678, 4'd6, got, ok);
        if (ok) begin
            check("xor_equal_result",  got.r, 32'd0);
            check("xor_equal_zero",    {31'd0, got.z}, 32'd1);
            check("xor_equal_illegal", {31'd0, got.il}, 32'd0);
        end
        send_one(32'hDEAD_BEEF, 32'h0123_4567, 4'd12, got, ok);
        if (ok) begin
            check("op12_result",  got.r, 32'd0);
            check("op12_zero",    {31'd0, got.z}, 32'd1);
            check("op12_illegal", {31'd0, got.il}, 32'd1);
        end
        send_one(32'hAAAA_AAAA, 32'hAAAA_AAAA, 4'd9, got, ok);
        if (ok) begin
`ifdef LOGIC_EXT_OPS_EN
            check("op9_result",  got.r, 32'hFFFF_FFFF);
            check("op9_illegal", {31'd0, got.il}, 32'd0);
`else
            check("op9_result",  got.r, 32'd0);
            check("op9_illegal", {31'd0, got.il}, 32'd1);
`endif
        end
        drain("drain_directed");

        // Stall: exactly two transactions fit, output must hold.
        n0 = accepts;
        bus.out_ready = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            bus.A = $urandom; bus.B = $urandom; bus.ALUop = 4'(4 + $urandom_range(0, 3));
            bus.in_valid = 1'b1;
            step();
            if (i == 2) held = bus.LogicOut;
        end
        check("stall_accepts", 32'(accepts - n0), 32'd2);
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall_hold", bus.LogicOut, held);
        n0 = pops;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_stall");
        check("stall_release_count", 32'(pops - n0), 32'd2);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.A = $urandom | 32'h1; bus.B = $urandom; bus.ALUop = 4'd5; bus.in_valid = 1'b1;
            step();
        end
        check("full_before_reset", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midreset_logicout",  bus.LogicOut, 32'd0);
        check("midreset_zero",      {31'd0, bus.zero}, 32'd0);
        check("midreset_illegal",   {31'd0, bus.illegal}, 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_stale_after_reset", {31'd0, bus.out_valid}, 32'd0);
        end

        // Randomized traffic against the reference queue.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.out_ready = ($urandom_range(0, 99) < 75);
            bus.A = $urandom;
            case ($urandom_range(0, 7))
                0:       bus.B = bus.A;
                1:       bus.B = ~bus.A;
                2:       bus.B = '0;
                default: bus.B = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) bus.ALUop = 4'($urandom_range(0, 15));
            else                           bus.ALUop = 4'(4 + $urandom_range(0, 7));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
